fir_coef_ctrl: RTL and testbench

Configuration controller for the parametrized FIR filter. It accepts a coefficient stream over a valid/ready handshake and assembles a complete set in a shadow bank. It then commits the set atomically to the active bank that drives the FIR coefficient array, and gates downstream output-valid while the filter settles. Malformed load sequences are rejected without disturbing the active coefficients.

---
 rtl/fir_coef_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fir_coef_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: coefficient configuration controller for the FIR filter.
// Collects a coefficient set over a valid/ready stream into a shadow bank,
// then swaps it atomically into the active bank and holds fir_out_valid low
// while the filter settles. Short or long sets are rejected and leave the
// active bank untouched.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cfg_valid/ready   coefficient beat handshake
//   cfg_data          signed coefficient, beat k is tap k
//   cfg_last          final beat of a set
//   coef_o            active coefficient array, index = tap
//   coef_valid        a set has been committed since reset
//   coef_update       one-cycle pulse after the active bank changes
//   fir_out_valid     coef_valid and not settling
//   busy              controller not idle
//   err               sticky error: 01 short set, 10 long set
module fir_coef_ctrl #(
  parameter int unsigned FILTER_LENGTH     = 4,
  parameter int unsigned COEFFICIENT_WIDTH = 16,
  parameter int unsigned SETTLE_CYCLES     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic signed [COEFFICIENT_WIDTH-1:0] cfg_data,
  input  logic                                cfg_last,
  output logic signed [COEFFICIENT_WIDTH-1:0] coef_o [FILTER_LENGTH],
  output logic                                coef_valid,
  output logic                                coef_update,
  output logic                                fir_out_valid,
  output logic                                busy,
  output logic [1:0]                          err
);

  localparam int unsigned IDX_W = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FILTER_LENGTH - 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_COMMIT,
    S_SETTLE
  } state_e;

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic signed [COEFFICIENT_WIDTH-1:0] shadow_q [FILTER_LENGTH];
  logic signed [COEFFICIENT_WIDTH-1:0] shadow_d [FILTER_LENGTH];
  logic signed [COEFFICIENT_WIDTH-1:0] active_q [FILTER_LENGTH];
  logic signed [COEFFICIENT_WIDTH-1:0] active_d [FILTER_LENGTH];
  logic [1:0]                          err_q, err_d;
  logic                                coef_valid_q, coef_valid_d;
  logic                                update_q, update_d;
  logic                                ready_q, ready_d;
  logic                                busy_q, busy_d;
  logic                                fov_q, fov_d;
  logic                                xfer;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= ERR_NONE;
      coef_valid_q <= 1'b0;
      update_q     <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      fov_q        <= 1'b0;
      for (int i = 0; i < int'(FILTER_LENGTH); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      coef_valid_q <= coef_valid_d;
      update_q     <= update_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      fov_q        <= fov_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  // Next-state, datapath update and registered-output next values
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    coef_valid_d = coef_valid_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    xfer         = cfg_valid & ready_q;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          shadow_d[0] = cfg_data;
          idx_d       = IDX_W'(1);
          err_d       = ERR_NONE;
          if (cfg_last) begin
            if (FILTER_LENGTH == 1) state_d = S_COMMIT;
            else                    err_d   = ERR_SHORT;
          end else if (FILTER_LENGTH == 1) begin
            err_d   = ERR_LONG;
            state_d = S_DRAIN;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          shadow_d[idx_q] = cfg_data;
          idx_d           = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            if (cfg_last) begin
              state_d = S_COMMIT;
            end else begin
              err_d   = ERR_LONG;
              state_d = S_DRAIN;
            end
          end else if (cfg_last) begin
            err_d   = ERR_SHORT;
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (xfer && cfg_last) state_d = S_IDLE;
      end
      S_COMMIT: begin
        // Whole-bank copy on a single edge keeps the swap atomic
        active_d     = shadow_q;
        coef_valid_d = 1'b1;
        cnt_d        = CNT_W'(SETTLE_CYCLES);
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DRAIN);
    busy_d   = (state_d != S_IDLE);
    update_d = (state_q == S_COMMIT);
    fov_d    = coef_valid_d && (state_d != S_COMMIT) && (state_d != S_SETTLE);
  end

  assign coef_o        = active_q;
  assign coef_valid    = coef_valid_q;
  assign coef_update   = update_q;
  assign fir_out_valid = fov_q;
  assign busy          = busy_q;
  assign cfg_ready     = ready_q;
  assign err           = err_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: a 4-tap / 1-cycle-settle instance and a
// 1-tap / 3-cycle-settle instance, with hand-computed expectations.
module tb_fir_coef_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic                a_valid, a_ready, a_last;
  logic signed [15:0]  a_data;
  logic signed [15:0]  a_coef [4];
  logic                a_cv, a_upd, a_fov, a_busy;
  logic [1:0]          a_err;

  logic                b_valid, b_ready, b_last;
  logic signed [15:0]  b_data;
  logic signed [15:0]  b_coef [1];
  logic                b_cv, b_upd, b_fov, b_busy;
  logic [1:0]          b_err;

  int total = 0;
  int bad   = 0;

  fir_coef_ctrl #(
    .FILTER_LENGTH(4), .COEFFICIENT_WIDTH(16), .SETTLE_CYCLES(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .cfg_valid(a_valid), .cfg_ready(a_ready), .cfg_data(a_data), .cfg_last(a_last),
    .coef_o(a_coef), .coef_valid(a_cv), .coef_update(a_upd),
    .fir_out_valid(a_fov), .busy(a_busy), .err(a_err)
  );

  fir_coef_ctrl #(
    .FILTER_LENGTH(1), .COEFFICIENT_WIDTH(16), .SETTLE_CYCLES(3)
  ) u_b (
    .clk(clk), .rst(rst),
    .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_data(b_data), .cfg_last(b_last),
    .coef_o(b_coef), .coef_valid(b_cv), .coef_update(b_upd),
    .fir_out_valid(b_fov), .busy(b_busy), .err(b_err)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat after gap idle cycles; returns #1 after the transfer edge
  task automatic send(input bit sel, input logic signed [15:0] d,
                      input logic last, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    if (sel) begin b_valid = 1'b1; b_data = d; b_last = last; end
    else     begin a_valid = 1'b1; a_data = d; a_last = last; end
    n = 0;
    while (((sel ? b_ready : a_ready) !== 1'b1) && (n < 16)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) chk("ready_timeout", 64'sd0, 64'sd1);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  logic signed [15:0] set1 [4] = '{16'sd1, 16'sd2, 16'sd3, -16'sd4};
  int gaps [4] = '{2, 0, 3, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    #12;
    chk("rst_ready",  64'(a_ready), 64'sd0);
    chk("rst_busy",   64'(a_busy),  64'sd0);
    chk("rst_cv",     64'(a_cv),    64'sd0);
    chk("rst_err",    64'(a_err),   64'sd0);
    chk("rst_fov",    64'(a_fov),   64'sd0);
    chk("rst_upd",    64'(a_upd),   64'sd0);
    chk("rst_coef0",  64'(a_coef[0]), 64'sd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rel_ready_a", 64'(a_ready), 64'sd1);
    chk("rel_ready_b", 64'(b_ready), 64'sd1);

    // Back-to-back good set
    send(1'b0, 16'sd1, 1'b0, 0);
    send(1'b0, 16'sd2, 1'b0, 0);
    send(1'b0, 16'sd3, 1'b0, 0);
    chk("load_busy",  64'(a_busy), 64'sd1);
    chk("load_cv",    64'(a_cv),   64'sd0);
    send(1'b0, -16'sd4, 1'b1, 0);
    chk("commit_ready", 64'(a_ready), 64'sd0);
    chk("commit_fov",   64'(a_fov),   64'sd0);
    chk("commit_upd",   64'(a_upd),   64'sd0);
    chk("commit_coef3", 64'(a_coef[3]), 64'sd0);
    step();
    for (int i = 0; i < 4; i++) chk("b2b_coef", 64'(a_coef[i]), 64'(set1[i]));
    chk("b2b_upd",   64'(a_upd),   64'sd1);
    chk("b2b_cv",    64'(a_cv),    64'sd1);
    chk("b2b_fov",   64'(a_fov),   64'sd0);
    chk("b2b_ready", 64'(a_ready), 64'sd0);
    step();
    chk("idle_ready", 64'(a_ready), 64'sd1);
    chk("idle_busy",  64'(a_busy),  64'sd0);
    chk("idle_upd",   64'(a_upd),   64'sd0);
    chk("idle_fov",   64'(a_fov),   64'sd1);

    // Same set with idle gaps between beats
    for (int i = 0; i < 4; i++) begin
      send(1'b0, set1[i], logic'(i == 3), gaps[i]);
      if (i < 3) begin
        chk("gap_busy", 64'(a_busy), 64'sd1);
        chk("gap_upd",  64'(a_upd),  64'sd0);
        chk("gap_fov",  64'(a_fov),  64'sd1);
      end
    end
    chk("gap_commit_ready", 64'(a_ready), 64'sd0);
    step();
    chk("gap_upd_pulse", 64'(a_upd), 64'sd1);
    for (int i = 0; i < 4; i++) chk("gap_coef", 64'(a_coef[i]), 64'(set1[i]));
    step();
    chk("gap_idle_busy", 64'(a_busy), 64'sd0);

    // Short set
    send(1'b0, 16'sd9, 1'b0, 0);
    send(1'b0, 16'sd9, 1'b1, 0);
    chk("short_err",   64'(a_err),   64'sd1);
    chk("short_ready", 64'(a_ready), 64'sd1);
    chk("short_busy",  64'(a_busy),  64'sd0);
    step();
    chk("short_upd",   64'(a_upd),   64'sd0);
    chk("short_coef0", 64'(a_coef[0]), 64'sd1);
    chk("short_coef1", 64'(a_coef[1]), 64'sd2);

    // Long set, drained, then a good set clears err
    send(1'b0, 16'sd5, 1'b0, 0);
    send(1'b0, 16'sd6, 1'b0, 0);
    send(1'b0, 16'sd7, 1'b0, 0);
    send(1'b0, 16'sd8, 1'b0, 0);
    chk("long_err",   64'(a_err),   64'sd2);
    chk("long_busy",  64'(a_busy),  64'sd1);
    chk("long_ready", 64'(a_ready), 64'sd1);
    send(1'b0, 16'sd10, 1'b0, 0);
    chk("drain_busy", 64'(a_busy), 64'sd1);
    send(1'b0, 16'sd11, 1'b1, 0);
    chk("drain_done_busy", 64'(a_busy), 64'sd0);
    chk("drain_err",       64'(a_err),  64'sd2);
    chk("drain_cv",        64'(a_cv),   64'sd1);
    for (int i = 0; i < 4; i++) chk("drain_coef", 64'(a_coef[i]), 64'(set1[i]));
    send(1'b0, 16'sh7FFF, 1'b0, 0);
    chk("clr_err", 64'(a_err), 64'sd0);
    send(1'b0, 16'sh8000, 1'b0, 0);
    send(1'b0, 16'sd0, 1'b0, 0);
    send(1'b0, 16'sd1, 1'b1, 0);
    step();
    chk("ext_upd",   64'(a_upd),     64'sd1);
    chk("ext_coef0", 64'(a_coef[0]), 64'sd32767);
    chk("ext_coef1", 64'(a_coef[1]), -64'sd32768);
    chk("ext_coef2", 64'(a_coef[2]), 64'sd0);
    chk("ext_coef3", 64'(a_coef[3]), 64'sd1);
    step();

    // Async reset in the middle of beat 3
    send(1'b0, 16'sd1, 1'b0, 0);
    send(1'b0, 16'sd2, 1'b0, 0);
    @(negedge clk);
    a_valid = 1'b1; a_data = 16'sd3; a_last = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_coef0", 64'(a_coef[0]), 64'sd0);
    chk("mrst_coef1", 64'(a_coef[1]), 64'sd0);
    chk("mrst_cv",    64'(a_cv),      64'sd0);
    chk("mrst_err",   64'(a_err),     64'sd0);
    chk("mrst_busy",  64'(a_busy),    64'sd0);
    chk("mrst_ready", 64'(a_ready),   64'sd0);
    a_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("mrst_rel_ready", 64'(a_ready), 64'sd1);
    chk("mrst_rel_coef0", 64'(a_coef[0]), 64'sd0);

    // Single-tap instance with three settle cycles
    send(1'b1, -16'sd7, 1'b1, 0);
    chk("b_commit_ready", 64'(b_ready), 64'sd0);
    chk("b_commit_busy",  64'(b_busy),  64'sd1);
    chk("b_fov_1", 64'(b_fov), 64'sd0);
    step();
    chk("b_coef",  64'(b_coef[0]), -64'sd7);
    chk("b_upd",   64'(b_upd), 64'sd1);
    chk("b_cv",    64'(b_cv),  64'sd1);
    chk("b_fov_2", 64'(b_fov), 64'sd0);
    step();
    chk("b_fov_3", 64'(b_fov), 64'sd0);
    step();
    chk("b_fov_4", 64'(b_fov), 64'sd0);
    step();
    chk("b_fov_5",   64'(b_fov),   64'sd1);
    chk("b_ready_5", 64'(b_ready), 64'sd1);
    chk("b_busy_5",  64'(b_busy),  64'sd0);
    send(1'b1, 16'sd5, 1'b0, 0);
    chk("b_long_err",  64'(b_err),  64'sd2);
    chk("b_long_busy", 64'(b_busy), 64'sd1);
    chk("b_long_coef", 64'(b_coef[0]), -64'sd7);
    send(1'b1, 16'sd6, 1'b1, 0);
    chk("b_drain_busy", 64'(b_busy), 64'sd0);
    chk("b_drain_err",  64'(b_err),  64'sd2);
    chk("b_drain_coef", 64'(b_coef[0]), -64'sd7);
    chk("b_drain_cv",   64'(b_cv),   64'sd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
